qam16_rx_demod: RTL and testbench

- Receive-side counterpart of the QAM-16 transmit chain: takes upsampled 16-bit signed I/Q samples, decimates by SPS at a fixed symbol phase, slices each rail to a 4-level decision and demaps it to a 4-bit symbol.
- Self-synchronising PRBS checker runs on the recovered symbols (x^4+x^3+1 sequence) and reports lock and error counts for loopback bring-up.
- Sits directly after the TX output / pulse-shaping filter in the loopback test path.

---
 rtl/qam16_rx_demod.sv | 216 +++++++++++++++++++++
 tb/tb_qam16_rx_demod.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qam16_rx_demod.sv
// QAM-16 receive demodulator: decimate, 4-level slice, Gray demap and PRBS (x^4+x^3+1) checker.
// Optional slicer-error accumulator is built when QAM16_RX_EVM_EN is defined.
module qam16_rx_demod #(
  parameter int unsigned SPS      = 11,
  parameter int unsigned PHASE    = 0,
  parameter int unsigned AMP      = 1,
  parameter int unsigned LOCK_CNT = 8,
  parameter int unsigned LOSS_CNT = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               in_valid,
  input  logic signed [15:0] din_i,
  input  logic signed [15:0] din_q,
  input  logic               clr_cnt,
  output logic               sym_valid,
  output logic        [3:0]  sym_data,
  output logic signed [2:0]  sym_i,
  output logic signed [2:0]  sym_q,
  output logic               locked,
  output logic        [15:0] err_cnt,
  output logic        [15:0] sym_cnt,
  output logic        [23:0] evm_acc
);

  localparam logic        [3:0]  LastPh   = 4'(SPS - 1);
  localparam logic        [3:0]  PhaseL   = 4'(PHASE);
  localparam logic signed [17:0] Thr      = 18'(2 * AMP);
  localparam logic        [7:0]  LockCntL = 8'(LOCK_CNT);
  localparam logic        [7:0]  LossCntL = 8'(LOSS_CNT);

  typedef enum logic [0:0] {StHunt, StLocked} state_e;

  function automatic logic signed [2:0] slice(input logic signed [17:0] v);
    if (v < -Thr)           return -3'sd3;
    else if (v < 18'sd0)    return -3'sd1;
    else if (v < Thr)       return 3'sd1;
    else                    return 3'sd3;
  endfunction

  function automatic logic [1:0] gray(input logic signed [2:0] lvl);
    logic [1:0] g;
    unique case (lvl)
      -3'sd3:  g = 2'b00;
      -3'sd1:  g = 2'b01;
      3'sd1:   g = 2'b11;
      default: g = 2'b10;
    endcase
    return g;
  endfunction

  function automatic logic [3:0] nxt(input logic [3:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

  logic        [3:0]  phase_q;
  logic               strobe;
  logic signed [17:0] v_i, v_q;
  logic signed [2:0]  dec_i, dec_q;
  logic        [3:0]  rx_sym;

  logic               sym_valid_q;
  logic        [3:0]  sym_data_q;
  logic signed [2:0]  sym_i_q, sym_q_q;

  state_e             state_q;
  logic               locked_q;
  logic        [3:0]  pred_q;
  logic        [7:0]  good_q, bad_q;
  logic        [7:0]  good_nxt, bad_nxt;
  logic        [15:0] err_cnt_q, err_cnt_d;
  logic        [15:0] sym_cnt_q, sym_cnt_d;

  assign strobe = in_valid && (phase_q == PhaseL);
  assign v_i    = {{2{din_i[15]}}, din_i};
  assign v_q    = {{2{din_q[15]}}, din_q};
  assign dec_i  = slice(v_i);
  assign dec_q  = slice(v_q);
  assign rx_sym = {gray(dec_i), gray(dec_q)};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase_q <= '0;
    end else if (in_valid) begin
      phase_q <= (phase_q == LastPh) ? 4'd0 : phase_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sym_valid_q <= 1'b0;
      sym_data_q  <= '0;
      sym_i_q     <= '0;
      sym_q_q     <= '0;
    end else begin
      sym_valid_q <= strobe;
      if (strobe) begin
        sym_data_q <= rx_sym;
        sym_i_q    <= dec_i;
        sym_q_q    <= dec_q;
      end
    end
  end

  // Zero is never a valid PRBS state, so it can't count toward lock.
  assign good_nxt = ((rx_sym == pred_q) && (rx_sym != 4'd0)) ? good_q + 8'd1 : 8'd0;
  assign bad_nxt  = bad_q + 8'd1;

  // Checker state advances on the strobe edge, so locked moves together with sym_valid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StHunt;
      locked_q <= 1'b0;
      pred_q   <= '0;
      good_q   <= '0;
      bad_q    <= '0;
    end else if (strobe) begin
      unique case (state_q)
        StHunt: begin
          pred_q <= nxt(rx_sym);
          good_q <= good_nxt;
          if (good_nxt == LockCntL) begin
            state_q  <= StLocked;
            locked_q <= 1'b1;
            bad_q    <= '0;
          end
        end
        StLocked: begin
          pred_q <= nxt(pred_q);
          if (rx_sym == pred_q) begin
            bad_q <= '0;
          end else begin
            bad_q <= bad_nxt;
            if (bad_nxt == LossCntL) begin
              state_q  <= StHunt;
              locked_q <= 1'b0;
              good_q   <= '0;
            end
          end
        end
        default: state_q <= StHunt;
      endcase
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    sym_cnt_d = sym_cnt_q;
    if (clr_cnt) begin
      err_cnt_d = '0;
      sym_cnt_d = '0;
    end else if (strobe && (state_q == StLocked)) begin
      if (sym_cnt_q != '1) sym_cnt_d = sym_cnt_q + 16'd1;
      if ((rx_sym != pred_q) && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_cnt_q <= '0;
      sym_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
      sym_cnt_q <= sym_cnt_d;
    end
  end

`ifdef QAM16_RX_EVM_EN
  localparam logic signed [17:0] AmpS = 18'(AMP);

  logic signed [17:0] ref_i, ref_q, diff_i, diff_q;
  logic        [17:0] abs_i, abs_q;
  logic        [23:0] evm_sum;
  logic        [24:0] evm_wide;
  logic        [23:0] evm_q, evm_d;

  assign ref_i    = AmpS * {{15{dec_i[2]}}, dec_i};
  assign ref_q    = AmpS * {{15{dec_q[2]}}, dec_q};
  assign diff_i   = v_i - ref_i;
  assign diff_q   = v_q - ref_q;
  assign abs_i    = diff_i[17] ? 18'(-diff_i) : 18'(diff_i);
  assign abs_q    = diff_q[17] ? 18'(-diff_q) : 18'(diff_q);
  assign evm_sum  = {6'd0, abs_i} + {6'd0, abs_q};
  assign evm_wide = {1'b0, evm_q} + {1'b0, evm_sum};

  always_comb begin
    evm_d = evm_q;
    if (clr_cnt) begin
      evm_d = '0;
    end else if (strobe) begin
      evm_d = evm_wide[24] ? 24'hFF_FFFF : evm_wide[23:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      evm_q <= '0;
    end else begin
      evm_q <= evm_d;
    end
  end

  assign evm_acc = evm_q;
`else
  assign evm_acc = '0;
`endif

  assign sym_valid = sym_valid_q;
  assign sym_data  = sym_data_q;
  assign sym_i     = sym_i_q;
  assign sym_q     = sym_q_q;
  assign locked    = locked_q;
  assign err_cnt   = err_cnt_q;
  assign sym_cnt   = sym_cnt_q;

endmodule

// File: tb/tb_qam16_rx_demod.sv
// Directed bench for qam16_rx_demod: reset, slicer edges, PRBS lock/loss, gapped input, clear, EVM.
module tb_qam16_rx_demod;

  localparam int unsigned SPS      = 11;
  localparam int unsigned PHASE    = 0;
  localparam int unsigned AMP      = 1;
  localparam int unsigned LOCK_CNT = 8;
  localparam int unsigned LOSS_CNT = 4;

  logic               clk = 1'b0;
  logic               rstn;
  logic               in_valid;
  logic signed [15:0] din_i, din_q;
  logic               clr_cnt;
  logic               sym_valid;
  logic        [3:0]  sym_data;
  logic signed [2:0]  sym_i, sym_q;
  logic               locked;
  logic        [15:0] err_cnt, sym_cnt;
  logic        [23:0] evm_acc;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [3:0] st;

  always #5 clk = ~clk;

  qam16_rx_demod #(
    .SPS(SPS), .PHASE(PHASE), .AMP(AMP), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)
  ) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .din_i(din_i), .din_q(din_q),
    .clr_cnt(clr_cnt), .sym_valid(sym_valid), .sym_data(sym_data), .sym_i(sym_i),
    .sym_q(sym_q), .locked(locked), .err_cnt(err_cnt), .sym_cnt(sym_cnt), .evm_acc(evm_acc)
  );

  function automatic logic [3:0] prbs_nxt(input logic [3:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

  function automatic logic signed [15:0] lvl(input logic [1:0] g);
    case (g)
      2'b00:   return 16'(-3 * int'(AMP));
      2'b01:   return 16'(-1 * int'(AMP));
      2'b11:   return 16'(int'(AMP));
      default: return 16'(3 * int'(AMP));
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; in_valid = 1'b0; clr_cnt = 1'b0; din_i = '0; din_q = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic send_sample(input logic v, input logic signed [15:0] i,
                             input logic signed [15:0] q, input logic clr);
    @(negedge clk);
    in_valid = v; din_i = i; din_q = q; clr_cnt = clr;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One symbol period; captures outputs right after the strobe sample and one sample later.
  task automatic send_symbol(input logic [3:0] s, input logic gapped, input logic clr,
                             output logic sv_hi, output logic [3:0] sd, output int t_hi,
                             output logic sv_lo);
    sv_lo = 1'b1;
    for (int k = 0; k < int'(SPS); k++) begin
      send_sample(1'b1, lvl(s[3:2]), lvl(s[1:0]), clr && (k == int'(PHASE)));
      if (k == int'(PHASE)) begin
        sv_hi = sym_valid; sd = sym_data; t_hi = cyc;
      end else if (k == int'(PHASE) + 1) begin
        sv_lo = sym_valid;
      end
      if (gapped) send_sample(1'b0, 16'sd0, 16'sd0, 1'b0);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; in_valid = 1'b0; clr_cnt = 1'b0; din_i = '0; din_q = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'($urandom); din_i = 16'($urandom); din_q = 16'($urandom);
      clr_cnt = 1'($urandom);
    end
    #1;
    checks++;
    if ({sym_valid, sym_data, sym_i, sym_q, locked} !== 12'd0) begin
      errors++; $display("FAIL reset_dec got %h exp 0", {sym_valid, sym_data, sym_i, sym_q, locked});
    end
    checks++;
    if ({err_cnt, sym_cnt, evm_acc} !== 56'd0) begin
      errors++; $display("FAIL reset_cnt got %h exp 0", {err_cnt, sym_cnt, evm_acc});
    end
    @(negedge clk);
    rstn = 1'b1; in_valid = 1'b0; clr_cnt = 1'b0;
    send_sample(1'b1, 16'sd3, -16'sd3, 1'b0);
    checks++;
    if (sym_valid !== 1'b1) begin
      errors++; $display("FAIL first_strobe got %b exp 1", sym_valid);
    end
    checks++;
    if (sym_data !== 4'b1000) begin
      errors++; $display("FAIL first_data got %b exp 1000", sym_data);
    end
    send_sample(1'b1, 16'sd3, -16'sd3, 1'b0);
    checks++;
    if (sym_valid !== 1'b0) begin
      errors++; $display("FAIL strobe_width got %b exp 0", sym_valid);
    end
    // Partial period, then reset: the next valid sample must be a decision again.
    for (int k = 0; k < 3; k++) send_sample(1'b1, 16'sd0, 16'sd0, 1'b0);
    do_reset();
    send_sample(1'b1, -16'sd1, 16'sd1, 1'b0);
    checks++;
    if (sym_valid !== 1'b1 || sym_data !== 4'b0111) begin
      errors++; $display("FAIL midsym_reset got %b/%b exp 1/0111", sym_valid, sym_data);
    end
  endtask

  task automatic test_slicer();
    logic signed [15:0] vin [9];
    logic signed [2:0]  exp_l [9];
    logic        [1:0]  exp_g [9];
    vin   = '{-16'sd32768, -16'sd3, -16'sd2, -16'sd1, 16'sd0, 16'sd1, 16'sd2, 16'sd3, 16'sd32767};
    exp_l = '{-3'sd3, -3'sd3, -3'sd1, -3'sd1, 3'sd1, 3'sd1, 3'sd3, 3'sd3, 3'sd3};
    exp_g = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b11, 2'b11, 2'b10, 2'b10, 2'b10};
    do_reset();
    for (int n = 0; n < 9; n++) begin
      for (int k = 0; k < int'(SPS); k++) begin
        send_sample(1'b1, vin[n], 16'sd0, 1'b0);
        if (k == int'(PHASE)) begin
          checks++;
          if (sym_i !== exp_l[n] || sym_data[3:2] !== exp_g[n]) begin
            errors++;
            $display("FAIL slice_i[%0d] got %0d/%b exp %0d/%b", vin[n], sym_i, sym_data[3:2],
                     exp_l[n], exp_g[n]);
          end
          checks++;
          if (sym_q !== 3'sd1 || sym_data[1:0] !== 2'b11) begin
            errors++; $display("FAIL slice_q0 got %0d/%b exp 1/11", sym_q, sym_data[1:0]);
          end
        end
      end
    end
  endtask

  task automatic test_clean_loopback();
    logic sv_hi, sv_lo;
    logic [3:0] sd;
    int t;
    do_reset();
    st = 4'b1000;
    for (int k = 1; k <= 20; k++) begin
      send_symbol(st, 1'b0, 1'b0, sv_hi, sd, t, sv_lo);
      checks++;
      if (sv_hi !== 1'b1 || sv_lo !== 1'b0 || sd !== st || sym_data !== st) begin
        errors++;
        $display("FAIL loop_sym%0d got %b%b %b exp 10 %b", k, sv_hi, sv_lo, sd, st);
      end
      checks++;
      if (locked !== (k >= 9)) begin
        errors++; $display("FAIL loop_lock%0d got %b exp %b", k, locked, k >= 9);
      end
      checks++;
      if (sym_cnt !== 16'((k >= 10) ? k - 9 : 0) || err_cnt !== 16'd0) begin
        errors++;
        $display("FAIL loop_cnt%0d got sym %0d err %0d exp sym %0d err 0", k, sym_cnt, err_cnt,
                 (k >= 10) ? k - 9 : 0);
      end
      st = prbs_nxt(st);
    end
  endtask

  task automatic test_error_injection();
    logic sv_hi, sv_lo;
    logic [3:0] sd;
    int t;
    for (int k = 1; k <= 3; k++) begin
      send_symbol(st ^ 4'b0110, 1'b0, 1'b0, sv_hi, sd, t, sv_lo);
      st = prbs_nxt(st);
      checks++;
      if (locked !== 1'b1) begin
        errors++; $display("FAIL err3_lock%0d got %b exp 1", k, locked);
      end
    end
    checks++;
    if (err_cnt !== 16'd3) begin
      errors++; $display("FAIL err3_cnt got %0d exp 3", err_cnt);
    end
    send_symbol(st, 1'b0, 1'b0, sv_hi, sd, t, sv_lo);
    st = prbs_nxt(st);
    for (int k = 1; k <= 4; k++) begin
      send_symbol(st ^ 4'b0110, 1'b0, 1'b0, sv_hi, sd, t, sv_lo);
      st = prbs_nxt(st);
      checks++;
      if (locked !== (k < 4)) begin
        errors++; $display("FAIL err4_lock%0d got %b exp %b", k, locked, k < 4);
      end
    end
    checks++;
    if (err_cnt !== 16'd7) begin
      errors++; $display("FAIL err4_cnt got %0d exp 7", err_cnt);
    end
    for (int k = 1; k <= 8; k++) begin
      send_symbol(st, 1'b0, 1'b0, sv_hi, sd, t, sv_lo);
      st = prbs_nxt(st);
      checks++;
      if (locked !== (k == 8)) begin
        errors++; $display("FAIL relock%0d got %b exp %b", k, locked, k == 8);
      end
    end
    checks++;
    if (sym_cnt !== 16'd19 || err_cnt !== 16'd7) begin
      errors++; $display("FAIL relock_cnt got sym %0d err %0d exp 19 7", sym_cnt, err_cnt);
    end
  endtask

  task automatic test_gapped();
    logic sv_hi, sv_lo;
    logic [3:0] sd;
    int t, t_prev;
    do_reset();
    st = 4'b1000;
    t_prev = 0;
    for (int k = 1; k <= 12; k++) begin
      send_symbol(st, 1'b1, 1'b0, sv_hi, sd, t, sv_lo);
      checks++;
      if (sv_hi !== 1'b1 || sd !== st || locked !== (k >= 9)) begin
        errors++;
        $display("FAIL gap_sym%0d got %b %b %b exp 1 %b %b", k, sv_hi, sd, locked, st, k >= 9);
      end
      if (k >= 2) begin
        checks++;
        if (t - t_prev !== 22) begin
          errors++; $display("FAIL gap_spacing%0d got %0d exp 22", k, t - t_prev);
        end
      end
      t_prev = t;
      st = prbs_nxt(st);
    end
    checks++;
    if (sym_cnt !== 16'd3) begin
      errors++; $display("FAIL gap_symcnt got %0d exp 3", sym_cnt);
    end
    send_symbol(st ^ 4'b0110, 1'b1, 1'b1, sv_hi, sd, t, sv_lo);
    st = prbs_nxt(st);
    checks++;
    if (err_cnt !== 16'd0 || sym_cnt !== 16'd0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL clr_wins got err %0d sym %0d lk %b exp 0 0 1", err_cnt, sym_cnt, locked);
    end
    send_symbol(st ^ 4'b0110, 1'b1, 1'b0, sv_hi, sd, t, sv_lo);
    st = prbs_nxt(st);
    checks++;
    if (err_cnt !== 16'd1 || sym_cnt !== 16'd1) begin
      errors++; $display("FAIL after_clr got err %0d sym %0d exp 1 1", err_cnt, sym_cnt);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++;
    if (locked !== 1'b0 || err_cnt !== 16'd0 || sym_cnt !== 16'd0 || sym_data !== 4'd0) begin
      errors++;
      $display("FAIL async_reset got lk %b err %0d sym %0d data %b exp 0", locked, err_cnt,
               sym_cnt, sym_data);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_evm();
    logic [23:0] exp1, exp4;
`ifdef QAM16_RX_EVM_EN
    exp1 = 24'd2; exp4 = 24'd8;
`else
    exp1 = 24'd0; exp4 = 24'd0;
`endif
    do_reset();
    for (int n = 1; n <= 4; n++) begin
      for (int k = 0; k < int'(SPS); k++) send_sample(1'b1, 16'sd2, 16'sd2, 1'b0);
      if (n == 1) begin
        checks++;
        if (evm_acc !== exp1 || sym_i !== 3'sd3) begin
          errors++; $display("FAIL evm1 got %0d/%0d exp %0d/3", evm_acc, sym_i, exp1);
        end
      end
    end
    checks++;
    if (evm_acc !== exp4) begin
      errors++; $display("FAIL evm4 got %0d exp %0d", evm_acc, exp4);
    end
    send_sample(1'b0, 16'sd0, 16'sd0, 1'b1);
    checks++;
    if (evm_acc !== 24'd0) begin
      errors++; $display("FAIL evm_clr got %0d exp 0", evm_acc);
    end
  endtask

  initial begin
    test_reset();
    test_slicer();
    test_clean_loopback();
    test_error_injection();
    test_gapped();
    test_async_reset();
    test_evm();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
